conv2d_stream_engine: RTL
=========================

Name: conv2d_stream_engine

Overview:
- Parametrised successor to the fixed 8x8, 2-filter conv stage in the tt_um_mark28277 CNN pipeline.
- Accepts a frame of unsigned pixels over a valid/ready stream and buffers the whole frame.
- Computes a 3x3, stride-1, zero-padded ("same") convolution for NUM_FILT filters in parallel, one kernel tap per cycle.
- Emits one packed result word per output position over a valid/ready stream with backpressure. Weights and biases are runtime-loadable through a write port.

Parameters:
- IMG_W, 8, frame width in pixels (>=2)
- IMG_H, 8, frame height in pixels (>=2)
- DATA_W, 8, pixel and output element width
- NUM_FILT, 2, number of filters (output channels)
- W_W, 8, signed weight/bias width
- ACC_W, 20, signed accumulator width
- BIAS_SHIFT, 3, left shift applied to bias before accumulation
- OUT_SHIFT, 3, arithmetic right shift applied before clamping

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel valid
- in_ready  out  1  engine can accept a pixel
- in_data  in  DATA_W  unsigned pixel, raster order
- wt_we  in  1  weight/bias write strobe
- wt_addr  in  clog2(10*NUM_FILT)  address: f*9+k = weight k of filter f; 9*NUM_FILT+f = bias of filter f
- wt_data  in  W_W  signed weight/bias value
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_FILT*DATA_W  filter f result in bits [f*DATA_W +: DATA_W]
- out_last  out  1  marks the final position of a frame
- busy  out  1  high in MAC or EMIT

Behaviour:
- Clocking: clk; reset is synchronous and active-high.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, pixel and position counters 0, all weights and biases 0. Frame buffer contents are not cleared.
- States:
  - LOAD: in_ready=1. Each in_valid&&in_ready edge stores in_data at the pixel counter and increments it. On the edge accepting pixel IMG_W*IMG_H-1, go to MAC with position 0 and tap 0, and clear the accumulators.
  - MAC: in_ready=0. Exactly 9 cycles, taps k=0..8 in kernel raster order (dy=-1..1 outer, dx=-1..1 inner). Each cycle, acc[f] += pixel(x+dx, y+dy) * w[f][k]. Out-of-frame taps contribute 0. Pixel is zero-extended; the product is signed. After tap 8, register the results and go to EMIT.
  - EMIT: out_valid=1. out_data and out_last are held stable until out_ready is high.
    - On accept, if the position is the last one (IMG_W*IMG_H-1), go to LOAD with counters reset.
    - Otherwise increment the position, clear the accumulators and go to MAC.
- Result per filter: r = (acc + (bias <<< BIAS_SHIFT)) >>> OUT_SHIFT, evaluated at ACC_W. Then clamp to [0, 2^DATA_W-1].
- Overflow: the accumulator wraps silently. The chosen ACC_W must cover the worst case.
- Latency:
  - First out_valid is asserted 9 cycles after the edge that accepts the last pixel.
  - With out_ready held high, throughput is one result per 10 cycles.
  - A frame produces IMG_W*IMG_H outputs, in raster order.
- out_last=1 only with the final position's out_valid.
- Weight writes take effect in LOAD only. They are ignored in MAC/EMIT, and ignored for out-of-range addresses.
- in_valid outside LOAD has no effect. No pixel is lost or duplicated under arbitrary in_valid gaps.
- Reset mid-operation: returns to the reset state on the next edge and aborts the partial frame. Weights must be reloaded.

Optional Feature:
- Macro: CONV_SIGNED_OUT_EN.
- Defined: ReLU is removed. Each output element is signed two's complement, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the unsigned ReLU clamp [0, 2^DATA_W-1] described above.

Test Plan:
- Identity kernel (w[f][4]=8, others 0, biases 0), ramp pixels 0..63 -> outputs for both filters equal the input pixel. 64 outputs; out_last on the 64th only. First out_valid 9 cycles after the last pixel is accepted.
- Padding check: all pixels 8, all weights 1, bias 0 -> corner 4, edge 6, interior 9.
- Saturation/ReLU: pixels 255, filter 0 weights 127 -> 255; filter 1 weights -1 -> 0. With CONV_SIGNED_OUT_EN defined: filter 0 -> 0x7F, filter 1 -> 0x80.
- Bias: zero weights, bias0=3, bias1=-2 -> 3 and 0 (signed mode: 3 and 0xFE).
- Backpressure: out_ready held low 5 cycles at position 10 -> out_valid and out_data stable throughout. No position skipped; exactly 64 accepts per frame. in_ready stays 0 until the frame is done.
- Weight write during MAC is ignored (next frame result unchanged). Reset asserted during MAC of position 20 -> next cycle out_valid=0, in_ready=1, busy=0. A fresh frame after reloading weights gives correct results.

Source files
------------

// File: rtl/conv2d_stream_engine_if.sv
// Stream, weight-port and status signals of conv2d_stream_engine.
// master drives pixels/weights/out_ready; slave is the engine side.
interface conv2d_stream_engine_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_FILT = 2,
    parameter int W_W      = 8,
    parameter int AW       = $clog2(10*NUM_FILT)
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       wt_we;
    logic [AW-1:0]              wt_addr;
    logic [W_W-1:0]             wt_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_FILT*DATA_W-1:0] out_data;
    logic                       out_last;
    logic                       busy;

    modport master (
        output in_valid, in_data, wt_we, wt_addr, wt_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, wt_we, wt_addr, wt_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/conv2d_stream_engine.sv
// Frame-buffered 3x3 same-padded convolution, NUM_FILT filters, one tap per cycle.
// CONV_SIGNED_OUT_EN: signed saturated outputs instead of the unsigned ReLU clamp.
module conv2d_stream_engine #(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_FILT   = 2,
    parameter int W_W        = 8,
    parameter int ACC_W      = 20,
    parameter int BIAS_SHIFT = 3,
    parameter int OUT_SHIFT  = 3
) (
    input logic                   clk,
    input logic                   reset,
    conv2d_stream_engine_if.slave bus
);
    localparam int NPIX = IMG_W*IMG_H;
    localparam int PW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int AW   = $clog2(10*NUM_FILT);

`ifdef CONV_SIGNED_OUT_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] LO = ~HI;
`else
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 << DATA_W) - 1);
`endif

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_e;

    state_e                     state_q;
    logic [PW-1:0]              pix_q;
    logic [XW-1:0]              x_q;
    logic [YW-1:0]              y_q;
    logic [1:0]                 kx_q, ky_q;
    logic signed [ACC_W-1:0]    acc_q [NUM_FILT];
    logic signed [W_W-1:0]      w_q   [NUM_FILT][9];
    logic signed [W_W-1:0]      b_q   [NUM_FILT];
    logic [DATA_W-1:0]          fbuf_q [NPIX];
    logic                       in_ready_q, out_valid_q, out_last_q, busy_q;
    logic [NUM_FILT*DATA_W-1:0] out_data_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

    // Tap fetch: padding taps read as zero without touching the buffer.
    int               sx, sy;
    logic             in_frame;
    logic [PW-1:0]    rd_idx;
    logic [DATA_W-1:0] tap_pix;
    logic [3:0]       tap_k;

    assign tap_k = {2'b00, ky_q} * 4'd3 + {2'b00, kx_q};

    always_comb begin
        sx       = int'(x_q) + int'(kx_q) - 1;
        sy       = int'(y_q) + int'(ky_q) - 1;
        in_frame = (sx >= 0) && (sx < IMG_W) && (sy >= 0) && (sy < IMG_H);
        rd_idx   = '0;
        if (in_frame) rd_idx = PW'(sy*IMG_W + sx);
        tap_pix  = in_frame ? fbuf_q[rd_idx] : '0;
    end

    logic signed [ACC_W-1:0]    acc_nx [NUM_FILT];
    logic [NUM_FILT*DATA_W-1:0] res_word;

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        logic signed [ACC_W-1:0] pix_ext, w_ext, b_ext, r;
        logic signed [W_W-1:0]   w_cur;

        assign w_cur     = w_q[f][tap_k];
        assign pix_ext   = {{(ACC_W-DATA_W){1'b0}}, tap_pix};
        assign w_ext     = {{(ACC_W-W_W){w_cur[W_W-1]}}, w_cur};
        assign b_ext     = {{(ACC_W-W_W){b_q[f][W_W-1]}}, b_q[f]};
        assign acc_nx[f] = acc_q[f] + pix_ext * w_ext;
        assign r         = (acc_nx[f] + (b_ext <<< BIAS_SHIFT)) >>> OUT_SHIFT;
`ifdef CONV_SIGNED_OUT_EN
        assign res_word[f*DATA_W +: DATA_W] = (r > HI) ? HI[DATA_W-1:0] :
                                              (r < LO) ? LO[DATA_W-1:0] : r[DATA_W-1:0];
`else
        assign res_word[f*DATA_W +: DATA_W] = r[ACC_W-1] ? '0 :
                                              (r > HI) ? HI[DATA_W-1:0] : r[DATA_W-1:0];
`endif
    end

    // Frame buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == LOAD && bus.in_valid)
            fbuf_q[pix_q] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            pix_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            for (int f = 0; f < NUM_FILT; f++) begin
                acc_q[f] <= '0;
                b_q[f]   <= '0;
                for (int k = 0; k < 9; k++) w_q[f][k] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.wt_we) begin
                        for (int f = 0; f < NUM_FILT; f++) begin
                            for (int k = 0; k < 9; k++)
                                if (bus.wt_addr == AW'(f*9 + k)) w_q[f][k] <= bus.wt_data;
                            if (bus.wt_addr == AW'(9*NUM_FILT + f)) b_q[f] <= bus.wt_data;
                        end
                    end
                    if (bus.in_valid) begin
                        if (pix_q == PW'(NPIX-1)) begin
                            state_q    <= MAC;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            pix_q      <= '0;
                            x_q        <= '0;
                            y_q        <= '0;
                            kx_q       <= '0;
                            ky_q       <= '0;
                            for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= '0;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                MAC: begin
                    for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= acc_nx[f];
                    if (kx_q == 2'd2) begin
                        kx_q <= '0;
                        if (ky_q == 2'd2) begin
                            ky_q        <= '0;
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_word;
                            out_last_q  <= (x_q == XW'(IMG_W-1)) && (y_q == YW'(IMG_H-1));
                        end else begin
                            ky_q <= ky_q + 1'b1;
                        end
                    end else begin
                        kx_q <= kx_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            x_q        <= '0;
                            y_q        <= '0;
                        end else begin
                            state_q <= MAC;
                            for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= '0;
                            if (x_q == XW'(IMG_W-1)) begin
                                x_q <= '0;
                                y_q <= y_q + 1'b1;
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule
